// File: rtl/thermo_sweep_pkg.sv
// Shared types and constants for the thermometer sweep generator.
package thermo_sweep_pkg;

    typedef enum logic [1:0] {
        MODE_HOLD     = 2'd0,
        MODE_SAW_UP   = 2'd1,
        MODE_SAW_DOWN = 2'd2,
        MODE_TRI      = 2'd3
    } mode_e;

    localparam int unsigned BYTE_W = 8;

endpackage

// File: rtl/thermometer_encoder.sv
// Binary-to-thermometer encoder: output bit i is set when i is below the input value.
module thermometer_encoder #(
    parameter int unsigned IN_WIDTH  = 8,
    parameter int unsigned OUT_WIDTH = 2 ** IN_WIDTH
) (
    input  logic [IN_WIDTH-1:0]  din,
    output logic [OUT_WIDTH-1:0] dout
);

    always_comb begin
        dout = '0;
        for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
            dout[i] = (i < 32'(din));
        end
    end

endmodule

// File: rtl/thermo_sweep_gen.sv
// Programmable-step sweep counter feeding a thermometer bus, with a byte shift-loaded
// alternative pattern, a registered output and a byte-addressed readout mux.
module thermo_sweep_gen
    import thermo_sweep_pkg::*;
#(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned THERMO_W = 2 ** CNT_W,
    parameter int unsigned NBYTES   = THERMO_W / BYTE_W,
    parameter int unsigned RD_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cnt_en,
    input  logic [1:0]          mode,
    input  logic [CNT_W-1:0]    step,
    input  logic                shift_en,
    input  logic [BYTE_W-1:0]   shift_data,
    input  logic                src_sel,
    input  logic [RD_W-1:0]     rd_sel,
    output logic [CNT_W-1:0]    count,
    output logic                turn,
    output logic [THERMO_W-1:0] thermo_out,
    output logic [BYTE_W-1:0]   rd_byte
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    count_q, count_d;
    logic                dir_up_q, dir_up_d;
    logic                turn_q, turn_d;
    logic [THERMO_W-1:0] shift_q, shift_d;
    logic [THERMO_W-1:0] thermo_out_q, thermo_out_d;
    logic [THERMO_W-1:0] thermo;
    logic [CNT_W:0]      sum_ext, diff_ext;

    // Carry of the add doubles as the triangle "would overshoot MAX" test, and the
    // borrow of the subtract as the "would undershoot 0" test.
    assign sum_ext  = {1'b0, count_q} + {1'b0, step};
    assign diff_ext = {1'b0, count_q} - {1'b0, step};

    always_comb begin
        count_d  = count_q;
        dir_up_d = dir_up_q;
        turn_d   = 1'b0;
        if (cnt_en && (step != '0)) begin
            case (mode_e'(mode))
                MODE_SAW_UP: begin
                    count_d = sum_ext[CNT_W-1:0];
                    turn_d  = sum_ext[CNT_W];
                end
                MODE_SAW_DOWN: begin
                    count_d = diff_ext[CNT_W-1:0];
                    turn_d  = diff_ext[CNT_W];
                end
                MODE_TRI: begin
                    if (dir_up_q) begin
                        if (sum_ext[CNT_W]) begin
                            count_d  = CNT_MAX;
                            dir_up_d = 1'b0;
                            turn_d   = 1'b1;
                        end else begin
                            count_d = sum_ext[CNT_W-1:0];
                        end
                    end else begin
                        if (diff_ext[CNT_W]) begin
                            count_d  = '0;
                            dir_up_d = 1'b1;
                            turn_d   = 1'b1;
                        end else begin
                            count_d = diff_ext[CNT_W-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    thermometer_encoder #(
        .IN_WIDTH  (CNT_W),
        .OUT_WIDTH (THERMO_W)
    ) u_encoder (
        .din  (count_q),
        .dout (thermo)
    );

    always_comb begin
        shift_d = shift_q;
        if (shift_en) begin
            shift_d = {shift_q[THERMO_W-BYTE_W-1:0], shift_data};
        end
        thermo_out_d = src_sel ? shift_q : thermo;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= '0;
            dir_up_q     <= 1'b1;
            turn_q       <= 1'b0;
            shift_q      <= '0;
            thermo_out_q <= '0;
        end else begin
            count_q      <= count_d;
            dir_up_q     <= dir_up_d;
            turn_q       <= turn_d;
            shift_q      <= shift_d;
            thermo_out_q <= thermo_out_d;
        end
    end

    // Out-of-range indices read as zero (only reachable when NBYTES is not a power of 2).
    always_comb begin
        rd_byte = '0;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (32'(rd_sel) == b) begin
                rd_byte = thermo_out_q[b*BYTE_W +: BYTE_W];
            end
        end
    end

    assign count      = count_q;
    assign turn       = turn_q;
    assign thermo_out = thermo_out_q;

endmodule

// File: tb/tb_thermo_sweep_gen.sv
// Self-checking bench for thermo_sweep_gen: fixed vector table, directed corner sequences
// and a randomized run against a behavioural model.
module tb_thermo_sweep_gen;
    import thermo_sweep_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         cnt_en;
    logic [1:0]   mode;
    logic [7:0]   step;
    logic         shift_en;
    logic [7:0]   shift_data;
    logic         src_sel;
    logic [4:0]   rd_sel;
    logic [7:0]   count;
    logic         turn;
    logic [255:0] thermo_out;
    logic [7:0]   rd_byte;

    thermo_sweep_gen dut (
        .clk        (clk),
        .rst        (rst),
        .cnt_en     (cnt_en),
        .mode       (mode),
        .step       (step),
        .shift_en   (shift_en),
        .shift_data (shift_data),
        .src_sel    (src_sel),
        .rd_sel     (rd_sel),
        .count      (count),
        .turn       (turn),
        .thermo_out (thermo_out),
        .rd_byte    (rd_byte)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int           m_count;
    bit           m_dir;
    bit           m_turn;
    logic [255:0] m_out;
    logic [7:0]   m_sh[$];   // most recent byte at index 0

    typedef struct {
        bit         do_rst;
        logic [1:0] mode;
        logic [7:0] step;
        logic [7:0] exp_count;
        bit         exp_turn;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] thermo_of(input int c);
        logic [255:0] v = '0;
        for (int i = 0; i < c; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [255:0] sh_vec();
        logic [255:0] v = '0;
        for (int k = 0; k < m_sh.size(); k++) v[8*k +: 8] = m_sh[k];
        return v;
    endfunction

    task automatic model_reset();
        m_count = 0;
        m_dir   = 1'b1;
        m_turn  = 1'b0;
        m_out   = '0;
        m_sh.delete();
    endtask

    // One clock: model consumes the currently driven inputs, then DUT is compared.
    task automatic cycle();
        logic [255:0] nxt;
        int st;
        int s;
        nxt = src_sel ? sh_vec() : thermo_of(m_count);
        st  = int'(step);
        m_turn = 1'b0;
        if (cnt_en && st != 0) begin
            case (mode)
                2'd1: begin
                    s = m_count + st;
                    m_turn = (s > 255);
                    m_count = s % 256;
                end
                2'd2: begin
                    s = m_count - st;
                    m_turn = (s < 0);
                    m_count = (s + 256) % 256;
                end
                2'd3: begin
                    if (m_dir) begin
                        if (m_count + st > 255) begin
                            m_count = 255; m_dir = 1'b0; m_turn = 1'b1;
                        end else m_count = m_count + st;
                    end else begin
                        if (m_count - st < 0) begin
                            m_count = 0; m_dir = 1'b1; m_turn = 1'b1;
                        end else m_count = m_count - st;
                    end
                end
                default: ;
            endcase
        end
        if (shift_en) begin
            m_sh.push_front(shift_data);
            if (m_sh.size() > 32) void'(m_sh.pop_back());
        end
        m_out = nxt;
        @(posedge clk);
        #1;
        check("count", count, m_count[7:0]);
        check("turn", turn, m_turn);
        check("thermo_out", thermo_out, m_out);
        check("rd_byte", rd_byte, m_out[int'(rd_sel)*8 +: 8]);
    endtask

    // Called just after a sampled edge; asserts reset between edges.
    task automatic async_reset();
        #3 rst = 1'b1;
        #1;
        check("rst_count", count, 0);
        check("rst_turn", turn, 0);
        check("rst_thermo_out", thermo_out, 0);
        check("rst_rd_byte", rd_byte, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_b [3];
        int turns;
        int prev;

        rst = 1'b0; cnt_en = 1'b0; mode = 2'd0; step = '0; shift_en = 1'b0;
        shift_data = '0; src_sel = 1'b0; rd_sel = '0;
        #1 rst = 1'b1;
        #1;
        check("init_count", count, 0);
        check("init_turn", turn, 0);
        check("init_thermo_out", thermo_out, 0);
        check("init_rd_byte", rd_byte, 0);
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;

        // Vector table: {reset first, mode, step, expected count, expected turn}
        tbl.push_back('{1, MODE_TRI, 8'd100, 8'd100, 0});
        tbl.push_back('{0, MODE_TRI, 8'd100, 8'd200, 0});
        tbl.push_back('{0, MODE_TRI, 8'd100, 8'd255, 1});
        tbl.push_back('{0, MODE_TRI, 8'd100, 8'd155, 0});
        tbl.push_back('{0, MODE_TRI, 8'd100, 8'd55, 0});
        tbl.push_back('{0, MODE_TRI, 8'd100, 8'd0, 1});
        tbl.push_back('{0, MODE_TRI, 8'd100, 8'd100, 0});
        tbl.push_back('{1, MODE_SAW_UP, 8'd254, 8'd254, 0});
        tbl.push_back('{0, MODE_SAW_UP, 8'd3, 8'd1, 1});
        tbl.push_back('{1, MODE_SAW_UP, 8'd1, 8'd1, 0});
        tbl.push_back('{0, MODE_SAW_DOWN, 8'd3, 8'd254, 1});
        tbl.push_back('{1, MODE_TRI, 8'd0, 8'd0, 0});
        tbl.push_back('{0, MODE_SAW_UP, 8'd0, 8'd0, 0});
        tbl.push_back('{0, MODE_HOLD, 8'd5, 8'd0, 0});
        tbl.push_back('{1, MODE_SAW_UP, 8'd50, 8'd50, 0});
        tbl.push_back('{0, MODE_HOLD, 8'd50, 8'd50, 0});
        tbl.push_back('{0, MODE_SAW_DOWN, 8'd20, 8'd30, 0});
        tbl.push_back('{0, MODE_TRI, 8'd40, 8'd70, 0});
        tbl.push_back('{1, MODE_TRI, 8'd200, 8'd200, 0});
        tbl.push_back('{0, MODE_TRI, 8'd200, 8'd255, 1});
        tbl.push_back('{0, MODE_SAW_UP, 8'd1, 8'd0, 1});
        tbl.push_back('{0, MODE_SAW_UP, 8'd10, 8'd10, 0});
        tbl.push_back('{0, MODE_TRI, 8'd5, 8'd5, 0});   // direction kept (down) across modes

        cnt_en = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].do_rst) async_reset();
            mode = tbl[i].mode;
            step = tbl[i].step;
            cycle();
            check($sformatf("tbl%0d_count", i), count, tbl[i].exp_count);
            check($sformatf("tbl%0d_turn", i), turn, tbl[i].exp_turn);
        end

        // Full triangle sweep with step 1
        async_reset();
        mode = MODE_TRI; step = 8'd1; cnt_en = 1'b1; src_sel = 1'b0;
        turns = 0;
        for (int i = 0; i < 600; i++) begin
            prev = m_count;
            cycle();
            if (turn) turns++;
            check("popcount", $countones(thermo_out), prev);
        end
        check("sweep_turns", turns, 2);

        // Shift-loaded pattern with counter running
        async_reset();
        mode = MODE_SAW_UP; step = 8'd7; cnt_en = 1'b1; src_sel = 1'b1;
        shift_en = 1'b1;
        shift_data = 8'hA5; cycle();
        shift_data = 8'h3C; cycle();
        shift_data = 8'hFF; cycle();
        shift_en = 1'b0;
        cycle();
        exp_b[0] = 8'hFF; exp_b[1] = 8'h3C; exp_b[2] = 8'hA5;
        for (int r = 0; r < 3; r++) begin
            rd_sel = 5'(r);
            #1;
            check($sformatf("shift_rd%0d", r), rd_byte, exp_b[r]);
        end
        rd_sel = 5'd3;
        #1;
        check("shift_rd3", rd_byte, 0);
        check("count_running", count, 8'd28);
        rd_sel = '0; src_sel = 1'b0;

        // Async reset mid-sweep while descending at 77
        async_reset();
        mode = MODE_TRI; step = 8'd178;
        cycle(); cycle(); cycle();
        check("pre_rst_count", count, 8'd77);
        async_reset();
        step = 8'd1;
        cycle();
        check("post_rst_first", count, 8'd1);
        cycle();
        check("post_rst_second", count, 8'd2);

        // Randomized run
        for (int i = 0; i < 3000; i++) begin
            int r;
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 7) == 0) begin
                if (r == 0) step = '0;
                else if (r < 6) step = 8'($urandom_range(1, 4));
                else step = 8'($urandom);
            end
            cnt_en     = ($urandom_range(0, 7) != 0);
            shift_en   = 1'($urandom);
            shift_data = 8'($urandom);
            if ($urandom_range(0, 9) == 0) src_sel = ~src_sel;
            rd_sel     = 5'($urandom);
            if ($urandom_range(0, 199) == 0) async_reset();
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/thermo_sweep_gen.md
# thermo_sweep_gen

Parametrised thermometer-pattern generator, the next generation of the 8-bit triangle-counter/thermometer block. It drives a `THERMO_W`-bit thermometer bus from a programmable-step counter (hold, saw-up, saw-down, triangle) or from a byte-wide shift-loaded pattern. It registers the selected pattern and exposes it both as a full bus and through a byte-addressed readout port for pad-limited top levels.

## Interface

Parameters:
- `CNT_W`, 8: counter width.
- `THERMO_W`, `2**CNT_W`: thermometer/shift width; must be a multiple of 8.
- `NBYTES`, `THERMO_W/8`: derived; number of readout bytes.

Ports:
- `clk`, in, 1: clock. The block has one clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `cnt_en`, in, 1: counter advances by one step per cycle while high.
- `mode`, in, 2: counter mode, of type `mode_e`.
- `step`, in, `CNT_W`: step size, unsigned.
- `shift_en`, in, 1: shifts `shift_data` into the pattern register.
- `shift_data`, in, 8: byte inserted at the LSB end.
- `src_sel`, in, 1: output source. 0 selects the encoder; 1 selects the shift register.
- `rd_sel`, in, `$clog2(NBYTES)`: readout byte index.
- `count`, out, `CNT_W`: current counter value.
- `turn`, out, 1: one-cycle pulse on wrap or direction reversal.
- `thermo_out`, out, `THERMO_W`: registered selected pattern.
- `rd_byte`, out, 8: `thermo_out[8*rd_sel +: 8]`.

## Operation

Counter. `MAX` is `2**CNT_W-1`. The counter updates only when `cnt_en` is high.
- `MODE_HOLD`: count is unchanged; `turn` stays 0.
- `MODE_SAW_UP`: count becomes `(count+step) mod 2**CNT_W`. `turn` is 1 when the add carries out.
- `MODE_SAW_DOWN`: count becomes `(count-step) mod 2**CNT_W`. `turn` is 1 when the subtract borrows.
- `MODE_TRI`: uses an internal `dir_up` flag.
  - Up: if `count > MAX-step`, count becomes `MAX`, `dir_up` becomes 0 and `turn` is 1; otherwise count becomes `count+step`.
  - Down: if `count < step`, count becomes 0, `dir_up` becomes 1 and `turn` is 1; otherwise count becomes `count-step`.
  - Landing exactly on `MAX` or 0 without clamping does not turn. The turn happens on the next step.
- `step == 0`: count holds in every mode and `turn` stays 0.
- A mode change takes effect on the next enabled cycle; `count` is kept.
- `dir_up` is kept across mode changes. It is only written in `MODE_TRI`.

Encoder. Purely combinational: `thermo[i] = (i < count)`.
- count 0 gives all zeros.
- count `MAX` gives bits `[MAX-1:0]` set and bit `MAX` clear.

Shift register:
- `shift_en=1`: `shift_q` becomes `{shift_q[THERMO_W-9:0], shift_data}`.
- The shift register is independent of the counter and of `src_sel`.

Output register. Every cycle, `thermo_out` takes `src_sel ? shift_q : thermo`. `thermo` is taken from the pre-update `count`.

Readout. `rd_byte` is a combinational mux from `thermo_out`. When `rd_sel >= NBYTES`, `rd_byte` is 0.

Reset values: `count=0`, `dir_up=1`, `turn=0`, `shift_q=0`, `thermo_out=0`, `rd_byte=0`.

## Timing

- `count` and `turn` are registered. Both change one edge after the enabled cycle.
- `thermo_out` lags `count` by one cycle. The value of `count` after edge k appears in `thermo_out` after edge k+1.
- A shifted byte appears in `thermo_out` one edge after its shift edge, provided `src_sel=1`.
- A `src_sel` toggle is visible on `thermo_out` after one edge.
- `shift_en` and `cnt_en` in the same cycle: both take effect; the two have no interaction.
- Reset asserted mid-sweep clears all state immediately and asynchronously. The first enabled cycle after release steps from 0 upward.

## Structure

- Package `thermo_sweep_pkg` holds:
  - `typedef enum logic [1:0] mode_e`: `MODE_HOLD=0`, `MODE_SAW_UP=1`, `MODE_SAW_DOWN=2`, `MODE_TRI=3`.
  - The byte width constant `BYTE_W=8`.
- Sub-module: reuse `thermometer_encoder` with `IN_WIDTH=CNT_W` and `OUT_WIDTH=THERMO_W`. It must implement `i < din` semantics.
- The counter, shift register, output register and readout mux live in the top module.

## Test plan

- Reset, then `MODE_TRI`, `step=1`, `cnt_en=1`, 600 cycles:
  - count runs 0→255→0.
  - `turn` pulses exactly once at 255 and once at 0.
  - `thermo_out` popcount equals the previous cycle's `count`.
- `MODE_TRI`, `step=100` from 0:
  - Sequence is 100, 200, 255 (turn), 155, 55, 0 (turn), 100.
- `MODE_SAW_UP`, `step=3` from 254: count goes to 1 with `turn=1`.
- `MODE_SAW_DOWN`, `step=3` from 1: count goes to 254 with `turn=1`.
- `src_sel=1`, shift in 0xA5, 0x3C, 0xFF:
  - Next cycle `rd_sel=0` reads 0xFF, `rd_sel=1` reads 0x3C, `rd_sel=2` reads 0xA5.
  - Meanwhile the counter keeps running.
- Assert `rst` asynchronously mid-sweep at count 77 with `dir_up=0`:
  - All outputs read 0 before the next edge.
  - After release, the first step gives count 1 in the up direction.
